// File: rtl/dct2_transpose_buf.sv
// Transpose buffer between the row and column passes of a 2-D DCT-II: collects S rows, replays S columns.
// Define DCT_TP_PINGPONG_EN for the two-bank build where filling the next block overlaps draining.
module dct2_transpose_buf #(
  parameter int W     = 16,
  parameter int LANES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_n,
  input  logic [W*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_n,
  output logic               out_last,
  output logic [W*LANES-1:0] out_data
);

  localparam int AW = $clog2(LANES);

  // Index of the last row/column for a block size code (S = 4 << n).
  function automatic logic [AW-1:0] last_idx(input logic [1:0] n);
    case (n)
      2'd0:    return AW'(3);
      2'd1:    return AW'(7);
      2'd2:    return AW'(15);
      default: return AW'(31);
    endcase
  endfunction

  logic [AW-1:0] rowcnt;
  logic [AW-1:0] colcnt;
  logic [1:0]    wr_n;
  logic [1:0]    rd_n;
  logic [AW-1:0] wr_last;
  logic [AW-1:0] rd_last;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wr_last  = last_idx(wr_n);
  assign rd_last  = last_idx(rd_n);

`ifdef DCT_TP_PINGPONG_EN

  logic [W-1:0]    mem [2][LANES][LANES];
  logic [1:0]      full;
  logic [1:0][1:0] size_q;
  logic            wr_bank;
  logic            rd_bank;

  // The first row of a block carries the size; later rows reuse the latched value.
  assign wr_n      = (rowcnt == '0) ? in_n : size_q[wr_bank];
  assign rd_n      = size_q[rd_bank];
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      size_q  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rowcnt  <= '0;
      colcnt  <= '0;
    end else begin
      if (in_fire) begin
        if (rowcnt == '0) size_q[wr_bank] <= in_n;
        if (rowcnt == wr_last) begin
          rowcnt        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          rowcnt <= rowcnt + 1'b1;
        end
      end
      // Fill completes only into an empty bank and drain only from a full one,
      // so the two flag updates below always touch different banks.
      if (out_fire) begin
        if (colcnt == rd_last) begin
          colcnt        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          colcnt <= colcnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the array has no reset; a bank is only read after a complete block has overwritten the visible region.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (AW'(k) <= wr_last) mem[wr_bank][rowcnt][k] <= in_data[k*W +: W];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < LANES; r++) begin
      if (out_valid && AW'(r) <= rd_last) out_data[r*W +: W] = mem[rd_bank][r][colcnt];
    end
  end

`else

  typedef enum logic {FILL, DRAIN} state_t;

  logic [W-1:0] mem [LANES][LANES];
  state_t       state;
  logic [1:0]   size_q;

  assign wr_n      = (rowcnt == '0) ? in_n : size_q;
  assign rd_n      = size_q;
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      size_q <= '0;
      rowcnt <= '0;
      colcnt <= '0;
    end else begin
      if (in_fire) begin
        if (rowcnt == '0) size_q <= in_n;
        if (rowcnt == wr_last) begin
          rowcnt <= '0;
          colcnt <= '0;
          state  <= DRAIN;
        end else begin
          rowcnt <= rowcnt + 1'b1;
        end
      end
      if (out_fire) begin
        if (colcnt == rd_last) begin
          colcnt <= '0;
          state  <= FILL;
        end else begin
          colcnt <= colcnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the array has no reset; only rows/columns below the current block size are ever read back.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (AW'(k) <= wr_last) mem[rowcnt][k] <= in_data[k*W +: W];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < LANES; r++) begin
      if (out_valid && AW'(r) <= rd_last) out_data[r*W +: W] = mem[r][colcnt];
    end
  end

`endif

  // Size and last flags are gated so an idle output bus is all zero.
  assign out_n    = out_valid ? rd_n : 2'b00;
  assign out_last = out_valid && (colcnt == rd_last);

endmodule

// File: tb/tb_dct2_transpose_buf.sv
// Self-checking bench for dct2_transpose_buf: table-driven blocks, scoreboard of expected columns,
// plus hand-written sequences for input stall, mid-drain reset and (two-bank build) overlap.
module tb_dct2_transpose_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_n;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_n;
  logic         out_last;
  logic [511:0] out_data;

  dct2_transpose_buf dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
    .out_last(out_last), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [1:0]   n;
  } col_t;

  typedef struct {
    logic [1:0] n_first;
    logic [1:0] n_rest;
    int         kind;     // 0: 16r+c, 1: 32r+c-512, 2: random
    int         rdy;      // 0: always ready, 1: 1-0-0-1, 2: random
    int         exp_cols;
    logic [1:0] exp_n;
  } vec_t;

  col_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           cols_seen = 0;
  int           prev_acc = -1;
  int           max_gap = 0;
  int           last_cycs[$];
  int           row0_neg = 0;
  int           rdy_mode = 0;
  int           rdy_phase = 0;
  bit           hold_pend = 0;
  logic [515:0] hold_val;
  col_t         mon_e;
  logic [15:0]  blk [32][32];

  task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rdy_phase == 0) || (rdy_phase == 3);
      default: out_ready = 1'($urandom_range(1));
    endcase
    rdy_phase = (rdy_phase + 1) % 4;
  end

  // Output monitor: hold stability, idle gating and scoreboard comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) check("hold_stable", {out_valid, out_last, out_n, out_data}, hold_val);
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_valid, out_last, out_n, out_data};
      if (!out_valid) begin
        check("idle_zero", {out_last, out_n, out_data}, '0);
      end else if (out_ready) begin
        check("col_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("col_data", out_data, mon_e.data);
          check("col_last", out_last, mon_e.last);
          check("col_n", out_n, mon_e.n);
        end
        cols_seen++;
        if (prev_acc >= 0 && cyc - prev_acc > max_gap) max_gap = cyc - prev_acc;
        prev_acc = cyc;
        if (out_last) last_cycs.push_back(cyc);
      end
    end
  end

  task automatic send_block(input logic [1:0] nf, input logic [1:0] nr, input int kind,
                            input bit chk_lat, output int stalls);
    int   s;
    bit   got;
    col_t e;
    s = 4 << nf;
    stalls = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        blk[r][c] = (kind == 0) ? 16'(16*r + c) : (kind == 1) ? 16'(r*32 + c - 512) : 16'($urandom);
    for (int j = 0; j < s; j++) begin
      e.data = '0;
      for (int r = 0; r < s; r++) e.data[r*16 +: 16] = blk[r][j];
      e.last = (j == s - 1);
      e.n    = nf;
      q.push_back(e);
    end
    for (int r = 0; r < s; r++) begin
      in_valid = 1'b1;
      in_n     = (r == 0) ? nf : nr;
      for (int k = 0; k < 32; k++) in_data[k*16 +: 16] = blk[r][k];
      got = 0;
      for (int t = 0; t < 500 && !got; t++) begin
        @(negedge clk);
        if (in_ready) got = 1;
        else stalls++;
      end
      check("row_accept", got, 1);
      if (r == 0) row0_neg = cyc;
      if (chk_lat && r == s - 1) check("valid_before_last", out_valid, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_n     = 2'b00;
    in_data  = '0;
    if (chk_lat) begin
      check("valid_after_last", out_valid, 1);
`ifndef DCT_TP_PINGPONG_EN
      check("ready_low_drain", in_ready, 0);
`endif
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    check("drain_done", q.size() == 0 && !out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[5];
  int   st;
  int   st2;
  int   b_done;

  initial begin
    vecs[0] = '{2'd0, 2'd0, 0, 0, 4, 2'd0};
    vecs[1] = '{2'd3, 2'd3, 1, 1, 32, 2'd3};
    vecs[2] = '{2'd1, 2'd3, 2, 0, 8, 2'd1};
    vecs[3] = '{2'd2, 2'd2, 2, 1, 16, 2'd2};
    vecs[4] = '{2'd1, 2'd1, 2, 2, 8, 2'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_n = 2'b00; in_data = '0; out_ready = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {out_valid, out_last, out_n, out_data}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_outputs", {out_valid, out_last, out_n, out_data}, '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      rdy_mode  = vecs[i].rdy;
      cols_seen = 0;
      send_block(vecs[i].n_first, vecs[i].n_rest, vecs[i].kind, 1, st);
      check("block_out_n", out_n, vecs[i].exp_n);
      wait_drain();
      check("block_cols", cols_seen, vecs[i].exp_cols);
      rdy_mode = 0;
    end

`ifndef DCT_TP_PINGPONG_EN
    // Input held valid across the drain of an 8x8 block.
    rdy_mode = 0;
    last_cycs.delete();
    send_block(2'd1, 2'd1, 2, 0, st);
    send_block(2'd1, 2'd1, 2, 0, st2);
    check("drain_stall_cycles", st2, 8);
    check("row_after_last_col", row0_neg, last_cycs[0] + 1);
    wait_drain();
`else
    // Back-to-back 8x8 then 4x4 blocks overlapping fill and drain.
    rdy_mode = 0;
    last_cycs.delete();
    prev_acc = -1;
    max_gap  = 0;
    send_block(2'd1, 2'd1, 2, 0, st);
    send_block(2'd0, 2'd0, 0, 0, st);
    b_done = cyc;
    wait_drain();
    check("pp_overlap", b_done <= last_cycs[0], 1);
    check("pp_no_gap", max_gap, 1);
`endif

    // Reset after 3 of 16 columns, then a fresh 4x4 block.
    rdy_mode  = 0;
    cols_seen = 0;
    send_block(2'd2, 2'd2, 2, 0, st);
    for (int t = 0; t < 200 && cols_seen < 3; t++) @(negedge clk);
    check("mid_drain_cols", cols_seen, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_outputs", {out_valid, out_last, out_n, out_data}, '0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cols_seen = 0;
    send_block(2'd0, 2'd0, 0, 1, st);
    wait_drain();
    check("after_rst_cols", cols_seen, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
